fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have: be_redirect_valid  in  1, be_redirect_pc  in  32  backend redirect (exception/mispredict).
REQ-005 SHALL have: bp_redirect_valid  in  1, bp_redirect_pc  in  32  predictor redirect.
REQ-006 SHALL have: ic_req_valid  out  1, ic_req_ready  in  1, ic_req_pc  out  32  I-cache request; ic_req_pc 8-byte aligned.
REQ-007 SHALL have: ic_resp_valid  in  1, ic_resp_data  in  64  I-cache response; [31:0] is the word at pc&~7, [63:32] the word at +4.
REQ-008 SHALL have: out_valid  out  1, out_ready  in  1, out_pc0  out  32, out_pc1  out  32, out_inst0  out  32, out_inst1  out  32, out_inst0_valid  out  1, out_inst1_valid  out  1  fetch bundle to decode queue.
REQ-009 SHALL have: cur_pc  out  32  architectural fetch PC register.

Function
REQ-010 SHALL implement states IDLE, REQ, WAIT, HOLD, DRAIN; at most one I-cache request outstanding.
REQ-011 ic_req_valid SHALL be 1 only in REQ; ic_req_pc = cur_pc & 32'hFFFF_FFF8.
REQ-012 IDLE SHALL go to REQ next cycle unconditionally.
REQ-013 REQ: ic_req_valid&ic_req_ready SHALL go to WAIT and latch fetch_pc=cur_pc; otherwise stay REQ.
REQ-014 WAIT: ic_resp_valid SHALL capture ic_resp_data and fetch_pc into output registers, go to HOLD, and update cur_pc = (fetch_pc & 32'hFFFF_FFF8) + 8, wrapping modulo 2^32.
REQ-015 HOLD: out_valid=1; out_valid&out_ready SHALL go to REQ next cycle; otherwise stay HOLD with outputs stable.
REQ-016 Bundle fields SHALL be: out_pc0=fetch_pc&~7, out_pc1=(fetch_pc&~7)|4, out_inst0_valid=~fetch_pc[2], out_inst1_valid=1.
REQ-017 Redirect priority SHALL be rst > be_redirect > bp_redirect; selected target written to cur_pc with bits [1:0] cleared.
REQ-018 Redirect in IDLE/REQ without ic_req_ready SHALL update cur_pc and go/stay REQ; issued address follows the new cur_pc.
REQ-019 Redirect in REQ with ic_req_ready SHALL update cur_pc and go to DRAIN (accepted request is stale).
REQ-020 Redirect in WAIT without ic_resp_valid SHALL update cur_pc and go to DRAIN.
REQ-021 Redirect in WAIT with ic_resp_valid SHALL discard the response, update cur_pc, go to REQ; out_valid stays 0.
REQ-022 Redirect in HOLD SHALL update cur_pc, go to REQ, out_valid 0 next cycle; a same-cycle out handshake still counts as transferred.
REQ-023 DRAIN: ic_resp_valid SHALL discard data and go to REQ; further redirects in DRAIN update cur_pc only.
REQ-024 ic_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-025 Redirect with sequential update in the same cycle SHALL resolve to the redirect target.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, cur_pc=RESET_PC, out_valid=0, ic_req_valid=0, output data registers=0; rst overrides every other input.
REQ-027 rst asserted in WAIT/DRAIN SHALL abandon the outstanding request; any response arriving later in IDLE/REQ is ignored.
REQ-028 First ic_req_valid SHALL assert in the second cycle after rst deasserts.

Verification
REQ-029 Reset release, ready=1, response 1 cycle later -> ic_req_pc=BFC0_0000; bundle out_pc0=BFC0_0000, both valid; next ic_req_pc=BFC0_0008.
REQ-030 bp_redirect_pc=8000_0104 in HOLD -> bundle dropped; next ic_req_pc=8000_0100; bundle out_inst0_valid=0, out_pc1=8000_0104.
REQ-031 be_redirect_pc=8000_2000 and bp_redirect_pc=8000_3000 same cycle in WAIT, no resp -> DRAIN; next response discarded; ic_req_pc=8000_2000.
REQ-032 cur_pc=FFFF_FFF8 fetched -> cur_pc wraps to 0000_0000.
REQ-033 out_ready=0 for 5 cycles in HOLD -> outputs constant, ic_req_valid=0; out_ready=1 -> REQ next cycle.
REQ-034 rst in WAIT, late ic_resp_valid after release -> no out_valid, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//   Holds the architectural fetch PC. Issues one aligned 8-byte I-cache
//   request at a time and turns each response into a two-instruction fetch
//   bundle for the decode queue. Backend and predictor redirects overwrite
//   the PC. A request that was issued before a redirect is drained: its
//   response is discarded when it returns.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   be_redirect_valid/_pc          backend redirect (highest priority)
//   bp_redirect_valid/_pc          branch predictor redirect
//   ic_req_valid/_ready/_pc        I-cache request, pc 8-byte aligned
//   ic_resp_valid/_data            I-cache response, [31:0] = word at pc&~7
//   out_*                          fetch bundle, valid until out_ready
//   cur_pc                         architectural fetch PC
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        be_redirect_valid,
   input  logic [31:0] be_redirect_pc,
   input  logic        bp_redirect_valid,
   input  logic [31:0] bp_redirect_pc,
   output logic        ic_req_valid,
   input  logic        ic_req_ready,
   output logic [31:0] ic_req_pc,
   input  logic        ic_resp_valid,
   input  logic [63:0] ic_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1,
   output logic [31:0] out_inst0,
   output logic [31:0] out_inst1,
   output logic        out_inst0_valid,
   output logic        out_inst1_valid,
   output logic [31:0] cur_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t      state_q;
   logic [31:0] cur_pc_q;
   logic [31:0] fetch_pc_q;
   logic        ic_req_valid_q;
   logic        out_valid_q;
   logic [31:0] out_pc0_q;
   logic [31:0] out_pc1_q;
   logic [31:0] out_inst0_q;
   logic [31:0] out_inst1_q;
   logic        out_inst0_valid_q;
   logic        out_inst1_valid_q;

   logic        redir;
   logic [31:0] redir_pc;
   logic [31:0] fetch_base;
   logic [31:0] seq_pc_d;

   // Backend wins over predictor; targets are word aligned.
   assign redir      = be_redirect_valid | bp_redirect_valid;
   assign redir_pc   = (be_redirect_valid ? be_redirect_pc : bp_redirect_pc) & 32'hFFFF_FFFC;
   assign fetch_base = fetch_pc_q & 32'hFFFF_FFF8;
   // Next sequential line; wraps naturally at 2^32.
   assign seq_pc_d   = fetch_base + 32'd8;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= S_IDLE;
         cur_pc_q          <= RESET_PC;
         fetch_pc_q        <= '0;
         ic_req_valid_q    <= 1'b0;
         out_valid_q       <= 1'b0;
         out_pc0_q         <= '0;
         out_pc1_q         <= '0;
         out_inst0_q       <= '0;
         out_inst1_q       <= '0;
         out_inst0_valid_q <= 1'b0;
         out_inst1_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (redir) cur_pc_q <= redir_pc;
               state_q        <= S_REQ;
               ic_req_valid_q <= 1'b1;
            end
            S_REQ: begin
               if (redir) begin
                  cur_pc_q <= redir_pc;
                  // Request went out with the old PC: wait for it and drop it.
                  if (ic_req_ready) begin
                     state_q        <= S_DRAIN;
                     ic_req_valid_q <= 1'b0;
                  end
               end else if (ic_req_ready) begin
                  state_q        <= S_WAIT;
                  ic_req_valid_q <= 1'b0;
                  fetch_pc_q     <= cur_pc_q;
               end
            end
            S_WAIT: begin
               if (redir) begin
                  cur_pc_q <= redir_pc;
                  if (ic_resp_valid) begin
                     state_q        <= S_REQ;
                     ic_req_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end else if (ic_resp_valid) begin
                  state_q           <= S_HOLD;
                  out_valid_q       <= 1'b1;
                  out_pc0_q         <= fetch_base;
                  out_pc1_q         <= fetch_base | 32'h4;
                  out_inst0_q       <= ic_resp_data[31:0];
                  out_inst1_q       <= ic_resp_data[63:32];
                  // Entry into the upper word of a line skips the lower one.
                  out_inst0_valid_q <= ~fetch_pc_q[2];
                  out_inst1_valid_q <= 1'b1;
                  cur_pc_q          <= seq_pc_d;
               end
            end
            S_HOLD: begin
               // A handshake in the same cycle as a redirect still transfers.
               if (redir || out_ready) begin
                  if (redir) cur_pc_q <= redir_pc;
                  state_q        <= S_REQ;
                  ic_req_valid_q <= 1'b1;
                  out_valid_q    <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (redir) cur_pc_q <= redir_pc;
               if (ic_resp_valid) begin
                  state_q        <= S_REQ;
                  ic_req_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q        <= S_IDLE;
               ic_req_valid_q <= 1'b0;
               out_valid_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ic_req_valid    = ic_req_valid_q;
   assign ic_req_pc       = cur_pc_q & 32'hFFFF_FFF8;
   assign out_valid       = out_valid_q;
   assign out_pc0         = out_pc0_q;
   assign out_pc1         = out_pc1_q;
   assign out_inst0       = out_inst0_q;
   assign out_inst1       = out_inst1_q;
   assign out_inst0_valid = out_inst0_valid_q;
   assign out_inst1_valid = out_inst1_valid_q;
   assign cur_pc          = cur_pc_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: I-cache responses come from a fixed
// address-derived pattern; expected bundles are queued when a response is
// driven and compared when the bundle is taken.
module tb_fetch_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        be_redirect_valid;
   logic [31:0] be_redirect_pc;
   logic        bp_redirect_valid;
   logic [31:0] bp_redirect_pc;
   logic        ic_req_valid;
   logic        ic_req_ready;
   logic [31:0] ic_req_pc;
   logic        ic_resp_valid;
   logic [63:0] ic_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc0;
   logic [31:0] out_pc1;
   logic [31:0] out_inst0;
   logic [31:0] out_inst1;
   logic        out_inst0_valid;
   logic        out_inst1_valid;
   logic [31:0] cur_pc;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [31:0] i0;
      logic [31:0] i1;
      logic        v0;
      logic        v1;
   } bundle_t;

   bundle_t sb[$];

   fetch_pc_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk(clk), .rst(rst),
      .be_redirect_valid(be_redirect_valid), .be_redirect_pc(be_redirect_pc),
      .bp_redirect_valid(bp_redirect_valid), .bp_redirect_pc(bp_redirect_pc),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_pc(ic_req_pc),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc0(out_pc0), .out_pc1(out_pc1),
      .out_inst0(out_inst0), .out_inst1(out_inst1),
      .out_inst0_valid(out_inst0_valid), .out_inst1_valid(out_inst1_valid),
      .cur_pc(cur_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cmp_bundle(input bundle_t b);
      check("out_pc0", out_pc0, b.pc0);
      check("out_pc1", out_pc1, b.pc1);
      check("out_inst0", out_inst0, b.i0);
      check("out_inst1", out_inst1, b.i1);
      check1("out_inst0_valid", out_inst0_valid, b.v0);
      check1("out_inst1_valid", out_inst1_valid, b.v1);
   endtask

   task automatic wait_req(input logic [31:0] pc);
      for (int i = 0; i < 20 && ic_req_valid !== 1'b1; i++) tick();
      check1("req_valid", ic_req_valid, 1'b1);
      check("req_pc", ic_req_pc, pc & 32'hFFFF_FFF8);
   endtask

   task automatic issue();
      ic_req_ready = 1'b1;
      tick();
      ic_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] pc);
      logic [31:0] base;
      base          = pc & 32'hFFFF_FFF8;
      ic_resp_valid = 1'b1;
      ic_resp_data  = {mem_word(base | 32'h4), mem_word(base)};
      tick();
      ic_resp_valid = 1'b0;
      ic_resp_data  = '0;
   endtask

   // Full fetch of pc: request, optional response delay, response.
   task automatic fetch(input logic [31:0] pc, input int dly, input bit push);
      bundle_t b;
      logic [31:0] base;
      base = pc & 32'hFFFF_FFF8;
      wait_req(pc);
      issue();
      repeat (dly) tick();
      respond(pc);
      check1("hold_valid", out_valid, 1'b1);
      check("seq_pc", cur_pc, base + 32'd8);
      if (push) begin
         b.pc0 = base;
         b.pc1 = base | 32'h4;
         b.i0  = mem_word(base);
         b.i1  = mem_word(base | 32'h4);
         b.v0  = ~pc[2];
         b.v1  = 1'b1;
         sb.push_back(b);
      end
   endtask

   task automatic take();
      bundle_t b;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
      check1("take_valid", out_valid, 1'b1);
      if (out_valid === 1'b1 && sb.size() > 0) begin
         b = sb.pop_front();
         cmp_bundle(b);
      end
      tick();
      out_ready = 1'b0;
      check1("post_take_valid", out_valid, 1'b0);
      check1("post_take_req", ic_req_valid, 1'b1);
   endtask

   initial begin
      rst               = 1'b1;
      be_redirect_valid = 1'b1;
      be_redirect_pc    = 32'h1234_5678;
      bp_redirect_valid = 1'b0;
      bp_redirect_pc    = '0;
      ic_req_ready      = 1'b0;
      ic_resp_valid     = 1'b0;
      ic_resp_data      = '0;
      out_ready         = 1'b0;

      // Reset state, reset overriding a redirect
      repeat (3) tick();
      check("rst_cur_pc", cur_pc, 32'hBFC0_0000);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_req_valid", ic_req_valid, 1'b0);
      check("rst_pc0", out_pc0, 32'h0);
      check("rst_pc1", out_pc1, 32'h0);
      check("rst_inst0", out_inst0, 32'h0);
      check("rst_inst1", out_inst1, 32'h0);
      check1("rst_v0", out_inst0_valid, 1'b0);
      check1("rst_v1", out_inst1_valid, 1'b0);
      be_redirect_valid = 1'b0;
      rst = 1'b0;
      check1("release_idle", ic_req_valid, 1'b0);
      tick();
      check1("release_req", ic_req_valid, 1'b1);
      check("release_pc", ic_req_pc, 32'hBFC0_0000);

      // First sequential fetch
      fetch(32'hBFC0_0000, 0, 1);
      take();
      wait_req(32'hBFC0_0008);

      // Predictor redirect in HOLD drops the bundle
      fetch(32'hBFC0_0008, 0, 0);
      bp_redirect_valid = 1'b1;
      bp_redirect_pc    = 32'h8000_0104;
      tick();
      bp_redirect_valid = 1'b0;
      check1("hold_redir_drop", out_valid, 1'b0);
      check("hold_redir_pc", cur_pc, 32'h8000_0104);
      fetch(32'h8000_0104, 1, 1);
      take();

      // Back-pressure in HOLD
      fetch(32'h8000_0108, 2, 1);
      repeat (5) begin
         tick();
         check1("stall_valid", out_valid, 1'b1);
         check1("stall_req", ic_req_valid, 1'b0);
         if (sb.size() > 0) cmp_bundle(sb[0]);
      end
      take();

      // Backend beats predictor in WAIT, then drain
      wait_req(32'h8000_0110);
      issue();
      be_redirect_valid = 1'b1;
      be_redirect_pc    = 32'h8000_2000;
      bp_redirect_valid = 1'b1;
      bp_redirect_pc    = 32'h8000_3000;
      tick();
      be_redirect_valid = 1'b0;
      bp_redirect_valid = 1'b0;
      check("wait_redir_pc", cur_pc, 32'h8000_2000);
      check1("drain_req0", ic_req_valid, 1'b0);
      tick();
      check1("drain_req1", ic_req_valid, 1'b0);
      respond(32'h8000_0110);
      check1("drain_drop", out_valid, 1'b0);
      check1("drain_exit_req", ic_req_valid, 1'b1);
      check("drain_exit_pc", ic_req_pc, 32'h8000_2000);
      fetch(32'h8000_2000, 0, 1);
      take();

      // Redirect coinciding with response in WAIT
      wait_req(32'h8000_2008);
      issue();
      bp_redirect_valid = 1'b1;
      bp_redirect_pc    = 32'h8000_4006;
      respond(32'h8000_2008);
      bp_redirect_valid = 1'b0;
      check1("wait_resp_redir_ov", out_valid, 1'b0);
      check("wait_resp_redir_pc", cur_pc, 32'h8000_4004);
      check1("wait_resp_redir_req", ic_req_valid, 1'b1);
      check("wait_resp_redir_ipc", ic_req_pc, 32'h8000_4000);
      fetch(32'h8000_4004, 0, 1);
      take();

      // Redirect in REQ without and with ready
      be_redirect_valid = 1'b1;
      be_redirect_pc    = 32'h8000_6001;
      tick();
      be_redirect_valid = 1'b0;
      check("req_redir_pc", cur_pc, 32'h8000_6000);
      check1("req_redir_req", ic_req_valid, 1'b1);
      check("req_redir_ipc", ic_req_pc, 32'h8000_6000);
      be_redirect_valid = 1'b1;
      be_redirect_pc    = 32'h8000_5000;
      ic_req_ready      = 1'b1;
      tick();
      be_redirect_valid = 1'b0;
      ic_req_ready      = 1'b0;
      check1("req_rdy_redir_req", ic_req_valid, 1'b0);
      check("req_rdy_redir_pc", cur_pc, 32'h8000_5000);
      tick();
      check1("req_rdy_drain", ic_req_valid, 1'b0);
      respond(32'h8000_6000);
      check1("req_rdy_drop", out_valid, 1'b0);
      check("req_rdy_ipc", ic_req_pc, 32'h8000_5000);
      // Stray response in REQ is ignored
      respond(32'h8000_5000);
      check1("stray_ov", out_valid, 1'b0);
      check1("stray_req", ic_req_valid, 1'b1);
      fetch(32'h8000_5000, 0, 1);
      take();

      // Redirect in HOLD with same-cycle handshake
      fetch(32'h8000_5008, 0, 1);
      bp_redirect_valid = 1'b1;
      bp_redirect_pc    = 32'h8000_7000;
      take();
      bp_redirect_valid = 1'b0;
      check("hold_hs_redir_pc", cur_pc, 32'h8000_7000);
      check("hold_hs_redir_ipc", ic_req_pc, 32'h8000_7000);

      // PC wrap
      bp_redirect_valid = 1'b1;
      bp_redirect_pc    = 32'hFFFF_FFF8;
      tick();
      bp_redirect_valid = 1'b0;
      check("wrap_pre", cur_pc, 32'hFFFF_FFF8);
      fetch(32'hFFFF_FFF8, 0, 1);
      take();
      wait_req(32'h0000_0000);

      // Reset during WAIT, late response ignored
      issue();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("wrst_pc", cur_pc, 32'hBFC0_0000);
      check1("wrst_req", ic_req_valid, 1'b0);
      check1("wrst_ov", out_valid, 1'b0);
      respond(32'h0000_0000);
      check1("late_ov0", out_valid, 1'b0);
      check1("late_req", ic_req_valid, 1'b1);
      check("late_ipc", ic_req_pc, 32'hBFC0_0000);
      respond(32'h0000_0000);
      check1("late_ov1", out_valid, 1'b0);
      fetch(32'hBFC0_0000, 1, 1);
      take();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
